// File: rtl/axis_packet_classifier_if.sv
// Passive view of the packet gate's input stream: handshake, tlast and tuser metadata.
// The gate (or a bench) drives it as master; the classifier only observes it as slave.
interface axis_packet_classifier_if;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic [15:0] mon_tuser_size;
  logic [15:0] mon_tuser_src;
  logic [15:0] mon_tuser_dst;

  modport master (
    output mon_tvalid,
    output mon_tready,
    output mon_tlast,
    output mon_tuser_size,
    output mon_tuser_src,
    output mon_tuser_dst
  );

  modport slave (
    input mon_tvalid,
    input mon_tready,
    input mon_tlast,
    input mon_tuser_size,
    input mon_tuser_src,
    input mon_tuser_dst
  );
endinterface

// File: rtl/axis_packet_classifier.sv
// Per-packet allow/deny classifier: snoops the head beat's tuser metadata, matches it against a
// register-programmed rule table and holds one decision per packet until the head beat is taken.
module axis_packet_classifier #(
  parameter int unsigned RULES = 8,
  parameter int unsigned IDX_W = $clog2(RULES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axis_packet_classifier_if.slave       mon,
  input  logic                          default_allow,
  input  logic                          cfg_wr_en,
  input  logic [IDX_W-1:0]              cfg_addr,
  input  logic                          cfg_enable,
  input  logic [15:0]                   cfg_src,
  input  logic [15:0]                   cfg_src_mask,
  input  logic [15:0]                   cfg_dst,
  input  logic [15:0]                   cfg_dst_mask,
  input  logic [15:0]                   cfg_max_size,
  input  logic                          cfg_allow,
  output logic                          decision_valid,
  output logic                          decision_allow,
  output logic                          decision_hit,
  output logic [IDX_W-1:0]              decision_idx,
  output logic                          err_early,
  output logic [31:0]                   cnt_lookup,
  output logic [31:0]                   cnt_hit,
  output logic [31:0]                   cnt_deny
);

  typedef enum logic [1:0] {StWaitHead, StLookup, StDecide, StInPkt} state_e;

  state_e state_q, state_d;

  logic hs;
  assign hs = mon.mon_tvalid & mon.mon_tready;

  // Rule table
  logic        rule_en_q       [RULES];
  logic [15:0] rule_src_q      [RULES];
  logic [15:0] rule_src_mask_q [RULES];
  logic [15:0] rule_dst_q      [RULES];
  logic [15:0] rule_dst_mask_q [RULES];
  logic [15:0] rule_max_q      [RULES];
  logic        rule_allow_q    [RULES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RULES); i++) begin
        rule_en_q[i]       <= 1'b0;
        rule_src_q[i]      <= '0;
        rule_src_mask_q[i] <= '0;
        rule_dst_q[i]      <= '0;
        rule_dst_mask_q[i] <= '0;
        rule_max_q[i]      <= '0;
        rule_allow_q[i]    <= 1'b0;
      end
    end else if (cfg_wr_en && (32'(cfg_addr) < RULES)) begin
      rule_en_q[cfg_addr]       <= cfg_enable;
      rule_src_q[cfg_addr]      <= cfg_src;
      rule_src_mask_q[cfg_addr] <= cfg_src_mask;
      rule_dst_q[cfg_addr]      <= cfg_dst;
      rule_dst_mask_q[cfg_addr] <= cfg_dst_mask;
      rule_max_q[cfg_addr]      <= cfg_max_size;
      rule_allow_q[cfg_addr]    <= cfg_allow;
    end
  end

  logic [15:0] meta_size_q, meta_src_q, meta_dst_q;

  // Scan from the top so the lowest matching index is the one that sticks.
  logic             match_hit;
  logic             match_allow;
  logic [IDX_W-1:0] match_idx;

  always_comb begin
    match_hit   = 1'b0;
    match_allow = default_allow;
    match_idx   = '0;
    for (int i = int'(RULES) - 1; i >= 0; i--) begin
      if (rule_en_q[i] &&
          ((meta_src_q & rule_src_mask_q[i]) == (rule_src_q[i] & rule_src_mask_q[i])) &&
          ((meta_dst_q & rule_dst_mask_q[i]) == (rule_dst_q[i] & rule_dst_mask_q[i])) &&
          (meta_size_q <= rule_max_q[i])) begin
        match_hit   = 1'b1;
        match_allow = rule_allow_q[i];
        match_idx   = IDX_W'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitHead;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitHead: begin
        if (hs) begin
          state_d = mon.mon_tlast ? StWaitHead : StInPkt;
        end else if (mon.mon_tvalid) begin
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hs) begin
          state_d = mon.mon_tlast ? StWaitHead : StInPkt;
        end else begin
          state_d = StDecide;
        end
      end
      StDecide: begin
        if (hs) begin
          state_d = mon.mon_tlast ? StWaitHead : StInPkt;
        end
      end
      StInPkt: begin
        if (hs && mon.mon_tlast) begin
          state_d = StWaitHead;
        end
      end
      default: state_d = StWaitHead;
    endcase
  end

  // FSM outputs
  logic capture_meta, commit, early;

  always_comb begin
    decision_valid = 1'b0;
    capture_meta   = 1'b0;
    commit         = 1'b0;
    early          = 1'b0;
    unique case (state_q)
      StWaitHead: begin
        early        = hs;
        capture_meta = mon.mon_tvalid & ~hs;
      end
      StLookup: begin
        early  = hs;
        commit = ~hs;
      end
      StDecide: decision_valid = 1'b1;
      StInPkt:  ;
      default:  ;
    endcase
  end

  logic             dec_allow_q, dec_hit_q, err_early_q;
  logic [IDX_W-1:0] dec_idx_q;
  logic [31:0]      cnt_lookup_q, cnt_hit_q, cnt_deny_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_size_q  <= '0;
      meta_src_q   <= '0;
      meta_dst_q   <= '0;
      dec_allow_q  <= 1'b0;
      dec_hit_q    <= 1'b0;
      dec_idx_q    <= '0;
      err_early_q  <= 1'b0;
      cnt_lookup_q <= '0;
      cnt_hit_q    <= '0;
      cnt_deny_q   <= '0;
    end else begin
      if (capture_meta) begin
        meta_size_q <= mon.mon_tuser_size;
        meta_src_q  <= mon.mon_tuser_src;
        meta_dst_q  <= mon.mon_tuser_dst;
      end
      if (commit) begin
        dec_allow_q  <= match_allow;
        dec_hit_q    <= match_hit;
        dec_idx_q    <= match_idx;
        cnt_lookup_q <= cnt_lookup_q + 32'd1;
        if (match_hit)    cnt_hit_q  <= cnt_hit_q + 32'd1;
        if (!match_allow) cnt_deny_q <= cnt_deny_q + 32'd1;
      end
      if (early) begin
        err_early_q <= 1'b1;
      end
    end
  end

  assign decision_allow = dec_allow_q;
  assign decision_hit   = dec_hit_q;
  assign decision_idx   = dec_idx_q;
  assign err_early      = err_early_q;
  assign cnt_lookup     = cnt_lookup_q;
  assign cnt_hit        = cnt_hit_q;
  assign cnt_deny       = cnt_deny_q;

endmodule

// File: doc/axis_packet_classifier.md
Name: axis_packet_classifier

Overview:
- Produces the per-packet `decision_valid`/`decision_allow` consumed by the packet gate in box_250mhz.
- Passively monitors the gate's input stream (tvalid, tready, tlast and the tuser fields) and takes the head beat's tuser metadata while the gate stalls that beat.
- Matches the metadata against a small register-programmed rule table and holds a decision until the head beat is accepted.
- Tracks packet boundaries itself so that exactly one decision is issued per packet.

Parameters:
- RULES, 8, number of rule table entries (2..16).
- IDX_W, $clog2(RULES), width of the rule index.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- mon_tvalid  input  1  tvalid of the monitored stream.
- mon_tready  input  1  tready of the monitored stream, as driven by the gate.
- mon_tlast  input  1  tlast of the monitored stream.
- mon_tuser_size  input  16  packet size in bytes.
- mon_tuser_src  input  16  source id.
- mon_tuser_dst  input  16  destination id.
- default_allow  input  1  verdict applied when no rule matches.
- cfg_wr_en  input  1  rule write strobe.
- cfg_addr  input  IDX_W  rule index to write.
- cfg_enable  input  1  rule enable bit.
- cfg_src  input  16  source id to match.
- cfg_src_mask  input  16  source id mask.
- cfg_dst  input  16  destination id to match.
- cfg_dst_mask  input  16  destination id mask.
- cfg_max_size  input  16  maximum packet size for a match.
- cfg_allow  input  1  rule verdict.
- decision_valid  output  1  decision available for the current head beat.
- decision_allow  output  1  verdict.
- decision_hit  output  1  1 = a rule matched; 0 = default_allow was used.
- decision_idx  output  IDX_W  index of the matching rule.
- err_early  output  1  sticky flag: head beat was accepted before a decision existed.
- cnt_lookup  output  32  number of lookups performed.
- cnt_hit  output  32  number of lookups that matched a rule.
- cnt_deny  output  32  number of decisions issued with allow = 0.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in WAIT_HEAD.
  - Every rule entry cleared to enable = 0, so all decisions follow default_allow until rules are written.
- Definitions:
  - hs = mon_tvalid & mon_tready.
  - Writes: cfg_wr_en writes all rule fields at cfg_addr on the clock edge and are visible from the next cycle. An out-of-range cfg_addr is ignored.
- Rule match for a given rule:
  - enable = 1, and
  - (src & src_mask) == (rule_src & src_mask), and
  - (dst & dst_mask) == (rule_dst & dst_mask), and
  - size <= max_size (unsigned).
  - If several rules match, the lowest index wins.
- FSM:
  - WAIT_HEAD:
    - If mon_tvalid & !hs: register size/src/dst, go to LOOKUP.
    - If hs (head accepted with no decision): set err_early, no lookup. Go to WAIT_HEAD if mon_tlast, else IN_PKT.
  - LOOKUP (one cycle):
    - Evaluate the match against the table contents in this cycle; a same-cycle write is not seen.
    - Register allow, hit and idx.
    - Increment cnt_lookup, cnt_hit if hit, and cnt_deny if allow = 0.
    - Go to DECIDE.
    - If hs occurs here: set err_early, discard the result without incrementing counters, decision_valid stays 0. Go to WAIT_HEAD if mon_tlast, else IN_PKT.
  - DECIDE:
    - decision_valid = 1; allow, hit and idx are held stable.
    - On hs: decision_valid <= 0 on the next edge. Go to WAIT_HEAD if mon_tlast (single-beat packet), else IN_PKT.
    - mon_tvalid dropping without hs keeps DECIDE.
  - IN_PKT:
    - On hs & mon_tlast: go to WAIT_HEAD.
    - Non-handshaked beats are ignored.
- Latency: head-beat valid seen in cycle T gives decision_valid = 1 in cycle T+2.
- Counters wrap modulo 2^32. err_early is cleared only by reset.
- Reset asserted mid-packet or mid-decision returns everything to reset values immediately.

Test Plan:
- No rules, default_allow = 1; single-beat packet src = 0x0010, dst = 0x0020, size 64; mon_tready rises 1 cycle after decision_valid.
  - Expect decision_valid at T+2 with allow = 1, hit = 0.
  - Expect cnt_lookup = 1 and decision_valid cleared after hs.
- Rule 3 = {src 0x0010, mask 0xFFFF, dst don't-care (mask 0), max 1500, allow = 0} and rule 5 = same fields with allow = 1; default_allow = 1.
  - Expect allow = 0, hit = 1, idx = 3 (lowest index wins), cnt_deny = 1.
- Same rule 3; packet size 1501.
  - Expect no match, allow = default_allow, hit = 0.
  - Then size 1500: expect hit = 1, idx = 3.
- Four-beat packet with tready toggling 1010 after the decision, then a second packet back-to-back.
  - Expect exactly one decision per packet.
  - Second decision at 2 cycles after its head beat is presented; cnt_lookup = 2.
- Head beat handshaked in the same cycle mon_tvalid first rises.
  - Expect err_early = 1, no decision, cnt_lookup unchanged.
  - Next packet still decides normally.
- cfg write to rule 0 during LOOKUP, and rst_n pulsed during IN_PKT.
  - Expect the in-flight lookup to use the old rule 0.
  - After reset: outputs 0, table cleared, next packet follows default_allow.
